// File: rtl/rgb2ycbcr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rgb2ycbcr_pkg
//  Description : Shared types and elaboration-time helpers for the streaming
//                RGB -> YCbCr converter. It holds the colour-space mode enum,
//                the real-valued coefficient tables, fixed-point quantisation
//                with row-sum residue correction, and the per-channel offset
//                and clamp limits as functions of the component width.
//                Channel index: 0 = Y, 1 = Cb, 2 = Cr.
//                Term index:    0 = R, 1 = G, 2 = B.
//  Revision    : 1.0 - initial streaming release
// ============================================================================
package rgb2ycbcr_pkg;

    typedef enum logic {
        CSC_FULL   = 1'b0,   // JFIF full range
        CSC_STUDIO = 1'b1    // BT.601 studio range
    } csc_mode_e;

    localparam int c_CH_Y  = 0;
    localparam int c_CH_CB = 1;
    localparam int c_CH_CR = 2;

    // Real coefficient tables, one row per output channel.
    function automatic real coef_real(csc_mode_e mode, int chan, int idx);
        real k;
        k = 0.0;
        if (mode == CSC_FULL) begin
            case (chan * 3 + idx)
                0: k =  0.299;
                1: k =  0.587;
                2: k =  0.114;
                3: k = -0.168736;
                4: k = -0.331264;
                5: k =  0.5;
                6: k =  0.5;
                7: k = -0.418688;
                8: k = -0.081312;
                default: k = 0.0;
            endcase
        end else begin
            case (chan * 3 + idx)
                0: k =  0.256788;
                1: k =  0.504129;
                2: k =  0.097906;
                3: k = -0.148223;
                4: k = -0.290993;
                5: k =  0.439216;
                6: k =  0.439216;
                7: k = -0.367789;
                8: k = -0.071427;
                default: k = 0.0;
            endcase
        end
        return k;
    endfunction

    // round(c * 2^coef_w), rounding halves away from zero.
    function automatic int quant_coef(real c, int coef_w);
        real s;
        real x;
        s = 1.0;
        for (int i = 0; i < coef_w; i++) begin
            s = s * 2.0;
        end
        x = c * s;
        if (x >= 0.0) begin
            return $rtoi(x + 0.5);
        end
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    // Quantised coefficient with residue fix: the row of three quantised
    // terms must sum to the quantised row sum (2^coef_w for full-range Y,
    // 0 for chroma), so the largest-magnitude term absorbs any difference.
    function automatic int coef_q(csc_mode_e mode, int chan, int idx, int coef_w);
        int  q [3];
        int  qsum;
        int  target;
        int  big;
        real rsum;
        qsum = 0;
        rsum = 0.0;
        for (int i = 0; i < 3; i++) begin
            q[i] = quant_coef(coef_real(mode, chan, i), coef_w);
            qsum = qsum + q[i];
            rsum = rsum + coef_real(mode, chan, i);
        end
        target = quant_coef(rsum, coef_w);
        big    = 0;
        for (int i = 1; i < 3; i++) begin
            if (iabs(q[i]) > iabs(q[big])) begin
                big = i;
            end
        end
        q[big] = q[big] + (target - qsum);
        return q[idx];
    endfunction

    // Additive offset in output LSBs (before the fixed-point scale).
    function automatic int chan_offset(csc_mode_e mode, int chan, int pix_w);
        if (chan == c_CH_Y) begin
            return (mode == CSC_FULL) ? 0 : (16 << (pix_w - 8));
        end
        return (mode == CSC_FULL) ? (1 << (pix_w - 1)) : (128 << (pix_w - 8));
    endfunction

    function automatic int clamp_lo(csc_mode_e mode, int chan, int pix_w);
        if (mode == CSC_FULL || chan < 0) begin
            return 0;
        end
        return 16 << (pix_w - 8);
    endfunction

    function automatic int clamp_hi(csc_mode_e mode, int chan, int pix_w);
        if (mode == CSC_FULL) begin
            return (1 << pix_w) - 1;
        end
        return (chan == c_CH_Y) ? (235 << (pix_w - 8)) : (240 << (pix_w - 8));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb2ycbcr_stream_dot3.sv
`default_nettype none
// ============================================================================
//  Module      : ycc_dot3
//  Description : One output channel of the converter. Three registered
//                stages: S1 signed products of R/G/B with the mode-selected
//                coefficients, S2 row sum plus offset and rounding constant,
//                S3 arithmetic shift and clamp into the output register.
//                Each stage loads only on its enable; valid tracking lives
//                in the parent.
//  Ports       : clk, rst         clock, synchronous active-high reset
//                i_en_s1..i_en_s3 per-stage load enables
//                i_r, i_g, i_b    unsigned colour components
//                i_mode           conversion mode of the pixel entering S1
//                o_result         clamped channel value (S3 register)
//  Revision    : 1.0 - initial streaming release
// ============================================================================
module ycc_dot3
    import rgb2ycbcr_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 14,
    parameter int CHAN   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en_s1,
    input  logic             i_en_s2,
    input  logic             i_en_s3,
    input  logic [PIX_W-1:0] i_r,
    input  logic [PIX_W-1:0] i_g,
    input  logic [PIX_W-1:0] i_b,
    input  csc_mode_e        i_mode,
    output logic [PIX_W-1:0] o_result
);

    localparam int c_CW = COEF_W + 2;          // coefficient width
    localparam int c_PW = PIX_W + COEF_W + 2;  // product width
    localparam int c_SW = c_PW + 2;            // sum width with guard bits

    localparam logic signed [c_CW-1:0] c_KF_R = c_CW'(coef_q(CSC_FULL,   CHAN, 0, COEF_W));
    localparam logic signed [c_CW-1:0] c_KF_G = c_CW'(coef_q(CSC_FULL,   CHAN, 1, COEF_W));
    localparam logic signed [c_CW-1:0] c_KF_B = c_CW'(coef_q(CSC_FULL,   CHAN, 2, COEF_W));
    localparam logic signed [c_CW-1:0] c_KS_R = c_CW'(coef_q(CSC_STUDIO, CHAN, 0, COEF_W));
    localparam logic signed [c_CW-1:0] c_KS_G = c_CW'(coef_q(CSC_STUDIO, CHAN, 1, COEF_W));
    localparam logic signed [c_CW-1:0] c_KS_B = c_CW'(coef_q(CSC_STUDIO, CHAN, 2, COEF_W));

    // Offset pre-scaled to the fixed-point domain, plus half an LSB so the
    // later arithmetic shift rounds half up.
    localparam logic signed [c_SW-1:0] c_BIAS_F =
        c_SW'((chan_offset(CSC_FULL, CHAN, PIX_W) << COEF_W) + (1 << (COEF_W - 1)));
    localparam logic signed [c_SW-1:0] c_BIAS_S =
        c_SW'((chan_offset(CSC_STUDIO, CHAN, PIX_W) << COEF_W) + (1 << (COEF_W - 1)));

    localparam logic signed [c_SW-1:0] c_LO_F = c_SW'(clamp_lo(CSC_FULL,   CHAN, PIX_W));
    localparam logic signed [c_SW-1:0] c_HI_F = c_SW'(clamp_hi(CSC_FULL,   CHAN, PIX_W));
    localparam logic signed [c_SW-1:0] c_LO_S = c_SW'(clamp_lo(CSC_STUDIO, CHAN, PIX_W));
    localparam logic signed [c_SW-1:0] c_HI_S = c_SW'(clamp_hi(CSC_STUDIO, CHAN, PIX_W));

    // ---------------- S1: products ----------------
    logic signed [c_CW-1:0] w_k_r, w_k_g, w_k_b;
    logic signed [c_PW-1:0] w_x_r, w_x_g, w_x_b;
    logic signed [c_PW-1:0] w_c_r, w_c_g, w_c_b;
    logic signed [c_PW-1:0] w_p_r, w_p_g, w_p_b;

    assign w_k_r = (i_mode == CSC_STUDIO) ? c_KS_R : c_KF_R;
    assign w_k_g = (i_mode == CSC_STUDIO) ? c_KS_G : c_KF_G;
    assign w_k_b = (i_mode == CSC_STUDIO) ? c_KS_B : c_KF_B;

    // Components are unsigned: zero-extend; coefficients sign-extend.
    assign w_x_r = $signed({{(c_PW - PIX_W){1'b0}}, i_r});
    assign w_x_g = $signed({{(c_PW - PIX_W){1'b0}}, i_g});
    assign w_x_b = $signed({{(c_PW - PIX_W){1'b0}}, i_b});
    assign w_c_r = {{(c_PW - c_CW){w_k_r[c_CW-1]}}, w_k_r};
    assign w_c_g = {{(c_PW - c_CW){w_k_g[c_CW-1]}}, w_k_g};
    assign w_c_b = {{(c_PW - c_CW){w_k_b[c_CW-1]}}, w_k_b};

    // |coef| < 2^COEF_W, so each product fits c_PW bits without overflow.
    assign w_p_r = w_x_r * w_c_r;
    assign w_p_g = w_x_g * w_c_g;
    assign w_p_b = w_x_b * w_c_b;

    logic signed [c_PW-1:0] r_p_r, r_p_g, r_p_b;
    csc_mode_e              r_mode1;

    // ---------------- S2: sum + offset + round ----------------
    logic signed [c_SW-1:0] w_bias;
    logic signed [c_SW-1:0] w_sum;

    assign w_bias = (r_mode1 == CSC_STUDIO) ? c_BIAS_S : c_BIAS_F;
    assign w_sum  = {{2{r_p_r[c_PW-1]}}, r_p_r}
                  + {{2{r_p_g[c_PW-1]}}, r_p_g}
                  + {{2{r_p_b[c_PW-1]}}, r_p_b}
                  + w_bias;

    logic signed [c_SW-1:0] r_sum;
    csc_mode_e              r_mode2;

    // ---------------- S3: shift + clamp ----------------
    logic signed [c_SW-1:0] w_shift;
    logic signed [c_SW-1:0] w_lo, w_hi;
    logic [PIX_W-1:0]       w_clamped;

    assign w_shift = r_sum >>> COEF_W;
    assign w_lo    = (r_mode2 == CSC_STUDIO) ? c_LO_S : c_LO_F;
    assign w_hi    = (r_mode2 == CSC_STUDIO) ? c_HI_S : c_HI_F;

    always_comb begin
        w_clamped = w_shift[PIX_W-1:0];
        if (w_shift < w_lo) begin
            w_clamped = w_lo[PIX_W-1:0];
        end else if (w_shift > w_hi) begin
            w_clamped = w_hi[PIX_W-1:0];
        end
    end

    logic [PIX_W-1:0] r_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_r   <= '0;
            r_p_g   <= '0;
            r_p_b   <= '0;
            r_mode1 <= CSC_FULL;
            r_sum   <= '0;
            r_mode2 <= CSC_FULL;
            r_res   <= '0;
        end else begin
            if (i_en_s1) begin
                r_p_r   <= w_p_r;
                r_p_g   <= w_p_g;
                r_p_b   <= w_p_b;
                r_mode1 <= i_mode;
            end
            if (i_en_s2) begin
                r_sum   <= w_sum;
                r_mode2 <= r_mode1;
            end
            if (i_en_s3) begin
                r_res   <= w_clamped;
            end
        end
    end

    assign o_result = r_res;

endmodule
`default_nettype wire

// File: rtl/rgb2ycbcr_stream.sv
`default_nettype none
// ============================================================================
//  Module      : rgb2ycbcr_stream
//  Description : Streaming RGB -> YCbCr converter, one pixel per clock, with
//                valid/ready backpressure, per-pixel full/studio range mode,
//                round-half-up, saturation and a passthrough last flag.
//                Three-stage pipeline; stage valids and last flags are kept
//                here, arithmetic lives in three ycc_dot3 channel slices.
//  Ports       : clk, rst    clock, synchronous active-high reset
//                in_valid    input pixel valid
//                in_ready    input can be accepted this cycle
//                in_data     {B,G,R}, R in LSBs
//                in_mode     0 = full range, 1 = studio range
//                in_last     end-of-line/block marker, carried unchanged
//                out_valid   output pixel valid
//                out_ready   downstream accepts this cycle
//                out_data    {Cr,Cb,Y}, Y in LSBs
//                out_last    in_last of the same pixel
//  Revision    : 1.0 - initial streaming release
// ============================================================================
module rgb2ycbcr_stream
    import rgb2ycbcr_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3*PIX_W-1:0] in_data,
    input  logic               in_mode,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3*PIX_W-1:0] out_data,
    output logic               out_last
);

    logic r_v1, r_v2, r_v3;
    logic r_last1, r_last2, r_last3;

    // A stage is free to load when it is empty or its contents move on this
    // cycle. Chained combinationally so bubbles anywhere collapse at once.
    logic w_free1, w_free2, w_free3;
    logic w_ld1, w_ld2, w_ld3;

    assign w_free3 = !r_v3 || out_ready;
    assign w_free2 = !r_v2 || w_free3;
    assign w_free1 = !r_v1 || w_free2;

    // Data registers load only on a real pixel, which also keeps the
    // output register frozen while the output is stalled.
    assign w_ld1 = in_valid && w_free1;
    assign w_ld2 = r_v1 && w_free2;
    assign w_ld3 = r_v2 && w_free3;

    assign in_ready = w_free1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_last1 <= 1'b0;
            r_last2 <= 1'b0;
            r_last3 <= 1'b0;
        end else begin
            if (w_free1) begin
                r_v1 <= in_valid;
            end
            if (w_free2) begin
                r_v2 <= r_v1;
            end
            if (w_free3) begin
                r_v3 <= r_v2;
            end
            if (w_ld1) begin
                r_last1 <= in_last;
            end
            if (w_ld2) begin
                r_last2 <= r_last1;
            end
            if (w_ld3) begin
                r_last3 <= r_last2;
            end
        end
    end

    logic [2:0][PIX_W-1:0] w_res;
    csc_mode_e             w_mode;

    assign w_mode = csc_mode_e'(in_mode);

    generate
        for (genvar c = 0; c < 3; c++) begin : g_chan
            ycc_dot3 #(
                .PIX_W  (PIX_W),
                .COEF_W (COEF_W),
                .CHAN   (c)
            ) u_dot3 (
                .clk      (clk),
                .rst      (rst),
                .i_en_s1  (w_ld1),
                .i_en_s2  (w_ld2),
                .i_en_s3  (w_ld3),
                .i_r      (in_data[PIX_W-1:0]),
                .i_g      (in_data[2*PIX_W-1:PIX_W]),
                .i_b      (in_data[3*PIX_W-1:2*PIX_W]),
                .i_mode   (w_mode),
                .o_result (w_res[c])
            );
        end
    endgenerate

    assign out_valid = r_v3;
    assign out_data  = w_res;
    assign out_last  = r_last3;

endmodule
`default_nettype wire

// File: tb/tb_rgb2ycbcr_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb2ycbcr_stream
//  Description : Self-checking bench for rgb2ycbcr_stream (PIX_W=8,
//                COEF_W=14). Expected pixels are queued at acceptance and
//                compared when the DUT delivers them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb2ycbcr_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        in_mode;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_last;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rgb2ycbcr_stream #(
        .PIX_W  (8),
        .COEF_W (14)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    typedef struct {
        logic [23:0] data;
        logic        last;
        int          acc;
        bit          lat_chk;
    } exp_t;

    exp_t        sb[$];
    exp_t        pend;
    bit          accepted;
    int          n_vec = 0;
    int          n_err = 0;
    int          rdy_mode = 0;   // 0 = always ready, 1 = random, 2 = held low
    bit          prev_stall = 1'b0;
    logic [23:0] held_data;
    logic        held_last;

    // Reference: round(c*2^14) coefficients, rows summing to 2^14 (full Y)
    // or 0 (chroma); round half up; clamp to the range of the mode.
    function automatic logic [7:0] model_ch(int ch, bit studio, int r, int g, int b);
        int k [3];
        int off, lo, hi, acc;
        logic [31:0] v;
        if (!studio) begin
            lo = 0; hi = 255;
            case (ch)
                0:       begin k = '{4899, 9617, 1868};   off = 0;   end
                1:       begin k = '{-2765, -5427, 8192}; off = 128; end
                default: begin k = '{8192, -6860, -1332}; off = 128; end
            endcase
        end else begin
            lo = 16;
            case (ch)
                0:       begin k = '{4207, 8260, 1604};   off = 16;  hi = 235; end
                1:       begin k = '{-2428, -4768, 7196}; off = 128; hi = 240; end
                default: begin k = '{7196, -6026, -1170}; off = 128; hi = 240; end
            endcase
        end
        acc = k[0] * r + k[1] * g + k[2] * b + (off << 14) + 8192;
        acc = acc >>> 14;
        if (acc < lo) acc = lo;
        if (acc > hi) acc = hi;
        v = acc;
        return v[7:0];
    endfunction

    function automatic logic [23:0] model(int r, int g, int b, bit studio);
        return {model_ch(2, studio, r, g, b), model_ch(1, studio, r, g, b), model_ch(0, studio, r, g, b)};
    endfunction

    // One clock: observe at the falling edge, then update out_ready just
    // after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            n_vec++;
            if (in_ready !== ((sb.size() < 3) || (out_ready === 1'b1))) begin
                n_err++;
                $display("FAIL in_ready: got %b want %b (in flight %0d, out_ready %b)",
                         in_ready, (sb.size() < 3) || out_ready, sb.size(), out_ready);
            end
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             out_valid, out_data, out_last, held_data, held_last);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL stale_output: got d=%h with nothing outstanding, want no output", out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_last !== e.last) begin
                        n_err++;
                        $display("FAIL pixel: got d=%h l=%b want d=%h l=%b", out_data, out_last, e.data, e.last);
                    end
                    if (e.lat_chk) begin
                        n_vec++;
                        if (cyc - e.acc != 3) begin
                            n_err++;
                            $display("FAIL latency: got %0d clks want 3", cyc - e.acc);
                        end
                    end
                end
            end
            prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
            held_data  = out_data;
            held_last  = out_last;
            if (in_valid && in_ready === 1'b1) begin
                accepted = 1'b1;
                pend.acc = cyc;
                sb.push_back(pend);
            end
        end
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic set_ready_mode(input int m);
        rdy_mode  = m;
        out_ready = (m != 2);
    endtask

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input bit studio, input bit last, input logic [23:0] exp, input bit lat);
        in_valid     = 1'b1;
        in_data      = {b, g, r};
        in_mode      = studio;
        in_last      = last;
        pend.data    = exp;
        pend.last    = last;
        pend.lat_chk = lat;
        accepted     = 1'b0;
        for (int t = 0; t < 200 && !accepted; t++) tick();
        if (!accepted) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no in_ready in 200 clks want acceptance");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_rand(input bit last);
        logic [7:0] r, g, b;
        bit         m;
        r = 8'($urandom_range(0, 255));
        g = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        m = 1'($urandom_range(0, 1));
        send(r, g, b, m, last, model(r, g, b, m), 1'b0);
    endtask

    task automatic drain();
        for (int t = 0; t < 1000 && sb.size() > 0; t++) tick();
        if (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pixels outstanding want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        set_ready_mode(2);
        rst = 1'b1;
        repeat (3) tick();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 24'h0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b d=%h l=%b want v=0 d=000000 l=0", out_valid, out_data, out_last);
        end
        rst = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_full_range();
        set_ready_mode(0);
        send(8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 24'h808000, 1'b1);
        drain();
        send(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 24'h8080FF, 1'b1);
        drain();
        send(8'd255, 8'd0,   8'd0,   1'b0, 1'b0, 24'hFF554C, 1'b1);
        drain();
    endtask

    task automatic test_studio_alternating();
        set_ready_mode(0);
        send(8'd0,   8'd0,   8'd0,   1'b1, 1'b0, 24'h808010, 1'b1);
        send(8'd255, 8'd255, 8'd255, 1'b1, 1'b0, 24'h8080EB, 1'b1);
        send(8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 24'h808000, 1'b1);
        send(8'd255, 8'd255, 8'd255, 1'b1, 1'b0, 24'h8080EB, 1'b1);
        send(8'd255, 8'd0,   8'd0,   1'b0, 1'b0, 24'hFF554C, 1'b1);
        send(8'd255, 8'd0,   8'd0,   1'b1, 1'b0, 24'hF05A51, 1'b1);
        send(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 24'h8080FF, 1'b1);
        drain();
    endtask

    task automatic test_backpressure();
        set_ready_mode(1);
        for (int i = 0; i < 20; i++) send_rand(1'b0);
        drain();
        set_ready_mode(0);
    endtask

    task automatic test_reset_midflight();
        set_ready_mode(2);
        send(8'd10, 8'd20, 8'd30, 1'b0, 1'b0, model(10, 20, 30, 1'b0), 1'b0);
        send(8'd40, 8'd50, 8'd60, 1'b1, 1'b0, model(40, 50, 60, 1'b1), 1'b0);
        send(8'd70, 8'd80, 8'd90, 1'b0, 1'b1, model(70, 80, 90, 1'b0), 1'b0);
        repeat (3) tick();
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL full_stall: got in_ready=%b out_valid=%b want in_ready=0 out_valid=1", in_ready, out_valid);
        end
        rst = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 24'h0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL midflight_reset: got v=%b d=%h l=%b want v=0 d=000000 l=0", out_valid, out_data, out_last);
        end
        rst = 1'b0;
        sb.delete();
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
        set_ready_mode(0);
        send(8'd255, 8'd255, 8'd255, 1'b1, 1'b0, 24'h8080EB, 1'b1);
        drain();
        repeat (6) tick();
    endtask

    task automatic test_last_flag();
        set_ready_mode(0);
        for (int i = 1; i <= 64; i++) send_rand(i == 64);
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_full_range();
        test_studio_alternating();
        test_backpressure();
        test_reset_midflight();
        test_last_flag();
        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
